// File: rtl/seven_seg_mux.sv
// seven_seg_mux: time-multiplexed hex display driver with double-buffered, tear-free data update.
// Define SEVEN_SEG_MUX_LZB_EN to blank leading zero digits.
module seven_seg_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_CNT = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              digit,
    output logic                    pending,
    output logic                    frame_tick
);
    localparam int CW = $clog2(REFRESH_CNT + 2);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    scan_q, scan_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
    logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d, act_dp_q, act_dp_d;
    logic                    pend_q, pend_d, tick_q, tick_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              digit_q, digit_d;
    logic                    adv, frame;
    logic [6:0]              seg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            scan_q    <= 1'b0;
            idx_q     <= '0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            pend_q    <= 1'b0;
            tick_q    <= 1'b0;
            an_q      <= '1;
            digit_q   <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            scan_q    <= scan_d;
            idx_q     <= idx_d;
            sh_val_q  <= sh_val_d;
            sh_dp_q   <= sh_dp_d;
            act_val_q <= act_val_d;
            act_dp_q  <= act_dp_d;
            pend_q    <= pend_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            digit_q   <= digit_d;
        end
    end

    always_comb begin
        adv       = enable && cnt_q == CW'(REFRESH_CNT);
        cnt_d     = (!enable || adv) ? '0 : cnt_q + 1'b1;
        scan_d    = enable && (scan_q || adv);
        idx_d     = !enable ? '0 :
                    !adv ? idx_q :
                    (!scan_q || idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        frame     = adv && idx_d == '0;
        // a load landing on the frame boundary bypasses the shadow so SCAN(0) already shows it
        sh_val_d  = load ? value : sh_val_q;
        sh_dp_d   = load ? dp : sh_dp_q;
        act_val_d = (frame && load) ? value : (frame && pend_q) ? sh_val_q : act_val_q;
        act_dp_d  = (frame && load) ? dp : (frame && pend_q) ? sh_dp_q : act_dp_q;
        pend_d    = !frame && (load || pend_q);
    end

    always_comb begin
`ifdef SEVEN_SEG_MUX_LZB_EN
        seg     = (idx_d != '0 && (act_val_d >> (4 * idx_d)) == '0) ? 7'h7F : SEG[act_val_d[4*idx_d +: 4]];
`else
        seg     = SEG[act_val_d[4*idx_d +: 4]];
`endif
        an_d    = !enable ? '1 : adv ? ~(NUM_DIGITS'(1) << idx_d) : an_q;
        digit_d = !enable ? 8'hFF : adv ? {~act_dp_d[idx_d], seg} : digit_q;
        tick_d  = frame;
    end

    assign an         = an_q;
    assign digit      = digit_q;
    assign pending    = pend_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_seven_seg_mux.sv
// tb_seven_seg_mux: randomized and directed bench for seven_seg_mux against a time-arithmetic reference model.
module tb_seven_seg_mux;
    localparam int N = 4;
    localparam int R = 3;
    localparam logic [6:0] SEG [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [3:0] EXP_AN [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] EXP_DG [4] = '{8'hF9, 8'hA4, 8'hB0, 8'h99};

    logic        clk = 1'b0, reset = 1'b0, enable = 1'b0, load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  an;
    logic [7:0]  digit;
    logic        pending, frame_tick;
    int          errors = 0, checks = 0;

    seven_seg_mux #(.NUM_DIGITS(N), .REFRESH_CNT(R)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load), .value(value), .dp(dp),
        .an(an), .digit(digit), .pending(pending), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // model: position in the scan follows from the count of enabled cycles since restart
    int          t = 0, m_pos, m_top;
    bit          m_adv, m_bnd, m_pend = 0, m_ft = 0;
    logic [15:0] m_sh = '0, m_act = '0;
    logic [3:0]  m_shdp = '0, m_actdp = '0, m_an = 4'hF;
    logic [7:0]  m_dig = 8'hFF;
    logic [6:0]  m_seg;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            t = 0; m_sh = '0; m_act = '0; m_shdp = '0; m_actdp = '0;
            m_pend = 0; m_ft = 0; m_an = 4'hF; m_dig = 8'hFF;
        end else if (!enable) begin
            t = 0; m_ft = 0; m_an = 4'hF; m_dig = 8'hFF;
            if (load) begin m_sh = value; m_shdp = dp; m_pend = 1; end
        end else begin
            t++;
            m_adv = (t % (R + 1)) == 0;
            m_pos = (t / (R + 1) + N - 1) % N;
            m_bnd = m_adv && m_pos == 0;
            if (load && m_bnd) begin m_act = value; m_actdp = dp; m_pend = 0; end
            else if (load) begin m_sh = value; m_shdp = dp; m_pend = 1; end
            else if (m_bnd && m_pend) begin m_act = m_sh; m_actdp = m_shdp; m_pend = 0; end
            m_ft = m_bnd;
            if (m_adv) begin
                m_top = -1;
                for (int i = 0; i < N; i++) if (m_act[4*i +: 4] != 4'h0) m_top = i;
                m_seg = SEG[m_act[4*m_pos +: 4]];
`ifdef SEVEN_SEG_MUX_LZB_EN
                if (m_pos > 0 && m_pos > m_top) m_seg = 7'h7F;
`endif
                m_an  = ~(4'b1 << m_pos);
                m_dig = {~m_actdp[m_pos], m_seg};
            end
        end
    end

    task automatic test_reset;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %h want F", an); end
        checks++; if (digit !== 8'hFF) begin errors++; $display("FAIL reset_digit got %h want FF", digit); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL reset_pending got %b want 0", pending); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b want 0", frame_tick); end
        reset = 1'b0;
    endtask

    task automatic test_scan;
        int ft = 0, k;
        @(negedge clk); load = 1'b1; value = 16'h4321; dp = 4'h0;
        @(negedge clk); load = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL scan_pending got %b want 1", pending); end
        enable = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            checks++;
            if ({an, digit, pending, frame_tick} !== {m_an, m_dig, m_pend, m_ft}) begin
                errors++;
                $display("FAIL scan_model an=%h digit=%h pend=%b tick=%b want an=%h digit=%h pend=%b tick=%b",
                         an, digit, pending, frame_tick, m_an, m_dig, m_pend, m_ft);
            end
            if (c >= 3) begin
                k = ((c + 1) / 4 - 1) % 4;
                checks++;
                if ({an, digit} !== {EXP_AN[k], EXP_DG[k]}) begin
                    errors++;
                    $display("FAIL scan_seq cycle %0d an=%h digit=%h want an=%h digit=%h", c, an, digit, EXP_AN[k], EXP_DG[k]);
                end
            end
            ft += int'(frame_tick);
        end
        checks++; if (ft != 3) begin errors++; $display("FAIL scan_ticks got %0d want 3", ft); end
    endtask

    task automatic test_midframe;
        int n = 0;
        while (an !== 4'hD && n < 64) begin @(negedge clk); n++; end
        checks++; if (an !== 4'hD) begin errors++; $display("FAIL mid_wait an=%h want D", an); end
        load = 1'b1; value = 16'hABCD; dp = 4'h0;
        @(negedge clk); load = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL mid_pending got %b want 1", pending); end
        n = 0;
        while (an !== 4'hE && n < 64) begin
            if (an === 4'hB) begin
                checks++; if (digit !== 8'hB0) begin errors++; $display("FAIL mid_old2 got %h want B0", digit); end
            end
            if (an === 4'h7) begin
                checks++; if (digit !== 8'h99) begin errors++; $display("FAIL mid_old3 got %h want 99", digit); end
            end
            @(negedge clk); n++;
        end
        checks++; if (digit !== 8'hA1) begin errors++; $display("FAIL mid_new0 got %h want A1", digit); end
        checks++; if (pending !== 1'b0) begin errors++; $display("FAIL mid_cleared got %b want 0", pending); end
    endtask

    task automatic test_boundary;
        int n = 0;
        logic [15:0] v = 16'($urandom);
        logic [3:0] d = 4'($urandom);
        while (!(((t + 1) % (R + 1)) == 0 && (((t + 1) / (R + 1) + N - 1) % N) == 0) && n < 64) begin
            @(negedge clk); n++;
        end
        load = 1'b1; value = v; dp = d;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); load = 1'b0;
            if (c == 0) begin
                checks++;
                if ({an, digit} !== {4'hE, ~d[0], SEG[v[3:0]]}) begin
                    errors++;
                    $display("FAIL bnd_digit0 an=%h digit=%h want an=E digit=%h", an, digit, {~d[0], SEG[v[3:0]]});
                end
            end
            checks++; if (pending !== 1'b0) begin errors++; $display("FAIL bnd_pending cycle %0d got %b want 0", c, pending); end
        end
    endtask

    task automatic test_disable;
        int n = 0;
        while (an !== 4'hB && n < 64) begin @(negedge clk); n++; end
        enable = 1'b0;
        @(negedge clk);
        checks++; if ({an, digit} !== {4'hF, 8'hFF}) begin errors++; $display("FAIL dis_blank an=%h digit=%h want F FF", an, digit); end
        repeat (3) @(negedge clk);
        checks++; if (pending !== m_pend) begin errors++; $display("FAIL dis_pending got %b want %b", pending, m_pend); end
        enable = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (an !== 4'hE && n < 20);
        checks++; if (n != 4) begin errors++; $display("FAIL dis_restart got %0d cycles want 4", n); end
    endtask

    task automatic test_reset_pending;
        @(negedge clk); load = 1'b1; value = 16'h9876; dp = 4'hF;
        @(negedge clk); load = 1'b0;
        checks++; if (pending !== 1'b1) begin errors++; $display("FAIL rstp_pending_before got %b want 1", pending); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({an, digit, pending, frame_tick} !== {4'hF, 8'hFF, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rstp_async an=%h digit=%h pend=%b tick=%b want F FF 0 0", an, digit, pending, frame_tick);
        end
        @(negedge clk); reset = 1'b0;
        while (an !== 4'hE && t < 64) @(negedge clk);
        checks++; if (digit !== 8'hC0) begin errors++; $display("FAIL rstp_discard got %h want C0", digit); end
    endtask

    task automatic test_random;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            checks++;
            if ({an, digit, pending, frame_tick} !== {m_an, m_dig, m_pend, m_ft}) begin
                errors++;
                $display("FAIL rand_model cycle %0d an=%h digit=%h pend=%b tick=%b want an=%h digit=%h pend=%b tick=%b",
                         c, an, digit, pending, frame_tick, m_an, m_dig, m_pend, m_ft);
            end
            load  = ($urandom % 8) == 0;
            value = 16'($urandom);
            dp    = 4'($urandom);
            if (($urandom % 64) == 0) enable = ~enable;
        end
        enable = 1'b1; load = 1'b0;
    endtask

`ifdef SEVEN_SEG_MUX_LZB_EN
    task automatic test_lzb;
        localparam logic [7:0] LZ [4] = '{8'h92, 8'hFF, 8'h7F, 8'hFF};
        int n = 0;
        @(negedge clk); enable = 1'b1; load = 1'b1; value = 16'h0005; dp = 4'b0100;
        @(negedge clk); load = 1'b0;
        while (!frame_tick && n < 64) begin @(negedge clk); n++; end
        for (int c = 0; c < 16; c++) begin
            for (int i = 0; i < N; i++)
                if (an === ~(4'b1 << i)) begin
                    checks++; if (digit !== LZ[i]) begin errors++; $display("FAIL lzb_digit%0d got %h want %h", i, digit, LZ[i]); end
                end
            @(negedge clk);
        end
        load = 1'b1; value = 16'h0000; dp = 4'h0;
        @(negedge clk); load = 1'b0;
        n = 0;
        while (!frame_tick && n < 64) begin @(negedge clk); n++; end
        checks++; if (digit !== 8'hC0) begin errors++; $display("FAIL lzb_zero got %h want C0", digit); end
    endtask
`endif

    initial begin
        test_reset;
        test_scan;
        test_midframe;
        test_boundary;
        test_disable;
        test_reset_pending;
        test_random;
`ifdef SEVEN_SEG_MUX_LZB_EN
        test_lzb;
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_mux.md
SEVEN_SEG_MUX -- requirements
Module: seven_seg_mux

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL have parameter REFRESH_CNT, default 50000: per-digit dwell terminal count; dwell is REFRESH_CNT+1 clk cycles (1 ms at 50 MHz).
REQ-003 SHALL have port clk, input, 1: the single clock; all logic is on posedge clk.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: scan enable; when low, the display is blanked.
REQ-006 SHALL have port load, input, 1: single-cycle strobe that captures value and dp into the shadow register.
REQ-007 SHALL have port value, input, 4*NUM_DIGITS: hex nibbles; nibble i drives digit i, and digit 0 is least significant.
REQ-008 SHALL have port dp, input, NUM_DIGITS: decimal point request per digit, 1 = lit.
REQ-009 SHALL have port an, output, NUM_DIGITS: digit selects, active-low, one-hot-zero while scanning.
REQ-010 SHALL have port digit, output, 8: segments, active-low; bit7 = dp and bits6:0 = g,f,e,d,c,b,a.
REQ-011 SHALL have port pending, output, 1: high while shadow data is waiting for a frame boundary.
REQ-012 SHALL have port frame_tick, output, 1: one-cycle pulse in the cycle an selects digit 0.

Function
REQ-013 SHALL use a dwell counter that increments each cycle while enable=1 and clears to 0 in the cycle it equals REFRESH_CNT (an advance event).
REQ-014 SHALL keep a scan state of IDLE or SCAN(i). On an advance event, IDLE->SCAN(0), SCAN(i)->SCAN(i+1), and SCAN(NUM_DIGITS-1)->SCAN(0).
REQ-015 SHALL treat any advance into SCAN(0) as a frame boundary.
REQ-016 SHALL register an and digit; they update on the clock edge of the advance event, with no combinational path from inputs to outputs.
REQ-017 SHALL drive an[i]=0 and all other an bits =1 in SCAN(i), and drive an all-ones in IDLE.
REQ-018 SHALL decode nibbles to digit[6:0] as: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex).
REQ-019 SHALL set digit[7]=~dp[i] for the displayed digit i.
REQ-020 SHALL display only from the active register, never directly from value or dp.
REQ-021 SHALL, on load=1, copy value and dp into the shadow register and set pending=1.
REQ-022 SHALL, when a load occurs while pending=1, overwrite the shadow register so the last load wins.
REQ-023 SHALL, at a frame boundary with pending=1, copy shadow to active and clear pending on the same edge, so SCAN(0) shows the new data (tear-free).
REQ-024 SHALL, when load coincides with a frame boundary, write the loaded data straight to active and leave pending=0.
REQ-025 SHALL, when enable=0, clear the counter, force IDLE, set an to all-ones and digit to FF, and keep shadow, active and pending; load still works while disabled.
REQ-026 SHALL, when enable rises, restart exactly as after reset, with the first digit lit REFRESH_CNT+1 cycles later.
REQ-027 SHALL, for NUM_DIGITS=1, make every advance a frame boundary.

Reset
REQ-028 SHALL, while reset=1, asynchronously set an to all-ones, digit=FF, pending=0, frame_tick=0, counter=0, state=IDLE, and shadow/active value and dp to 0.
REQ-029 SHALL, when reset asserts mid-scan or mid-pending, immediately abort the scan and discard the shadow data.

Configuration
REQ-030 SHALL, with macro SEVEN_SEG_MUX_LZB_EN defined, blank leading zeros: for digits above the most significant nonzero nibble, digit[6:0]=7F, with dp still honoured; digit 0 is never blanked.
REQ-031 SHALL, with SEVEN_SEG_MUX_LZB_EN undefined, decode every digit per REQ-018 and contain no blanking logic.

Verification
REQ-032 SHALL cover: NUM_DIGITS=4, REFRESH_CNT=3, load value=4321, dp=0 -> an sequence E,D,B,7 with digit F9,A4,B0,99, each held 4 cycles, and frame_tick once per 16 cycles.
REQ-033 SHALL cover: load value=ABCD mid-frame during SCAN(1) -> pending=1, digits 2-3 still show the old data, then SCAN(0) shows A1 and pending=0.
REQ-034 SHALL cover: load on the exact frame-boundary cycle -> new digit-0 data in the same SCAN(0) and pending never rises.
REQ-035 SHALL cover: enable=0 during SCAN(2) -> an=F and digit=FF next cycle; on re-enable, the first an=E appears 4 cycles later.
REQ-036 SHALL cover: reset pulse during pending=1 -> outputs go to reset values without a clock edge and pending=0.
REQ-037 SHALL cover, with LZB_EN defined: value=0005, dp=0100 (binary) -> digit3=FF, digit2=7F, digit1=FF, digit0=92; value=0000 -> digit0=C0.
